// File: rtl/if_fetch_stage_if.sv
// Purpose: bundle of the IF-stage bus signals: stall vector and branch bus
//          from the pipeline, the IF->ID bus, the instruction SRAM request
//          and the fetch address-error flag.
// Ports (interface members):
//   stall           [STALL_W-1:0]    pipeline stall vector, bit 0 = IF stop
//   br_bus          [BR_W-1:0]       {br_e, br_addr[31:0]} from ID
//   if_to_id_bus    [IF_TO_ID_W-1:0] {ce, pc[31:0]} to ID
//   inst_sram_en    instruction SRAM enable
//   inst_sram_wen   [3:0]  byte write enables (fetch never writes)
//   inst_sram_addr  [31:0] SRAM address (current PC)
//   inst_sram_wdata [31:0] SRAM write data (unused, zero)
//   fetch_adel      address error on fetch for the current PC
// Modports: master = fetch stage, slave = surrounding pipeline / SRAM side.
interface if_fetch_stage_if #(
    parameter int unsigned STALL_W    = 6,
    parameter int unsigned BR_W       = 33,
    parameter int unsigned IF_TO_ID_W = 33
);
    logic [STALL_W-1:0]    stall;
    logic [BR_W-1:0]       br_bus;
    logic [IF_TO_ID_W-1:0] if_to_id_bus;
    logic                  inst_sram_en;
    logic [3:0]            inst_sram_wen;
    logic [31:0]           inst_sram_addr;
    logic [31:0]           inst_sram_wdata;
    logic                  fetch_adel;

    modport master (
        input  stall,
        input  br_bus,
        output if_to_id_bus,
        output inst_sram_en,
        output inst_sram_wen,
        output inst_sram_addr,
        output inst_sram_wdata,
        output fetch_adel
    );

    modport slave (
        output stall,
        output br_bus,
        input  if_to_id_bus,
        input  inst_sram_en,
        input  inst_sram_wen,
        input  inst_sram_addr,
        input  inst_sram_wdata,
        input  fetch_adel
    );
endinterface

// File: rtl/if_fetch_stage.sv
// Purpose: instruction-fetch stage of the five-stage MIPS pipeline. Owns the
//          PC, issues the instruction SRAM request and keeps a redirect that
//          arrives while IF is stalled so the branch target is never lost.
// Ports:
//   clk  clock (single domain)
//   rst  synchronous active-high reset
//   bus  if_fetch_stage_if.master: stall/br_bus in; if_to_id_bus,
//        inst_sram_* and fetch_adel out. All outputs come straight from
//        flops, with no combinational path from br_bus or stall.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'hBFBF_FFFC
) (
    input  logic               clk,
    input  logic               rst,
    if_fetch_stage_if.master   bus
);

    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned BR_E_BIT = 32;

    logic              stop_c;
    logic              br_e_c;
    logic [ADDR_W-1:0] br_addr_c;

    logic [ADDR_W-1:0] pc_q,        pc_d;
    logic              ce_q,        ce_d;
    logic              pend_v_q,    pend_v_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic              en_q,        en_d;
    logic              adel_q,      adel_d;

    // Only the IF stop bit is consumed; the rest of the vector belongs to later stages.
    logic unused_stall_c;
    assign unused_stall_c = ^bus.stall[$bits(bus.stall)-1:1];

    assign stop_c    = bus.stall[0];
    assign br_e_c    = bus.br_bus[BR_E_BIT];
    assign br_addr_c = bus.br_bus[ADDR_W-1:0];

    // Next PC / pending-redirect selection.
    always_comb begin
        pc_d        = pc_q;
        ce_d        = ce_q;
        pend_v_d    = pend_v_q;
        pend_addr_d = pend_addr_q;

        if (stop_c) begin
            // Latest redirect during a stall wins.
            if (br_e_c) begin
                pend_v_d    = 1'b1;
                pend_addr_d = br_addr_c;
            end
        end else begin
            ce_d     = 1'b1;
            pend_v_d = 1'b0;
            if (br_e_c) begin
                pc_d = br_addr_c;
            end else if (pend_v_q) begin
                pc_d = pend_addr_q;
            end else begin
                pc_d = pc_q + ADDR_W'(4);
            end
        end

        // Flag/enable are pre-computed from the next PC so they leave a flop.
        adel_d = ce_d & (pc_d[1:0] != 2'b00);
        en_d   = ce_d & (pc_d[1:0] == 2'b00);
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            ce_q        <= 1'b0;
            pend_v_q    <= 1'b0;
            pend_addr_q <= '0;
            en_q        <= 1'b0;
            adel_q      <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            ce_q        <= ce_d;
            pend_v_q    <= pend_v_d;
            pend_addr_q <= pend_addr_d;
            en_q        <= en_d;
            adel_q      <= adel_d;
        end
    end

    // Misaligned PCs are still forwarded to ID so the exception is tagged with them.
    assign bus.if_to_id_bus    = {ce_q, pc_q};
    assign bus.inst_sram_en    = en_q;
    assign bus.inst_sram_wen   = 4'b0000;
    assign bus.inst_sram_addr  = pc_q;
    assign bus.inst_sram_wdata = 32'h0;
    assign bus.fetch_adel      = adel_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'hBFBF_FFFC;

    logic clk;
    logic rst;

    int unsigned vectors;
    int unsigned miscompares;

    // Reference model: architectural PC, fetch-valid and a queue holding the
    // redirect target remembered across a stall (empty = nothing pending).
    logic [31:0] m_pc;
    logic        m_ce;
    logic [31:0] m_pend[$];

    if_fetch_stage_if bus ();

    if_fetch_stage #(.RESET_PC(RESET_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected output bundle {if_to_id_bus, en, adel, addr, wen, wdata}.
    function automatic logic [102:0] expect_vec();
        logic misal;
        misal = m_ce && (m_pc % 4 != 0);
        return {m_ce, m_pc, m_ce && !misal, misal, m_pc, 4'b0000, 32'h0};
    endfunction

    function automatic logic [102:0] observe_vec();
        return {bus.if_to_id_bus, bus.inst_sram_en, bus.fetch_adel,
                bus.inst_sram_addr, bus.inst_sram_wen, bus.inst_sram_wdata};
    endfunction

    // Apply one cycle of inputs, advance the model, sample #1 after the edge.
    task automatic step(input logic r, input logic [5:0] st, input logic be,
                        input logic [31:0] ba);
        rst        = r;
        bus.stall  = st;
        bus.br_bus = {be, ba};
        @(posedge clk);
        if (r) begin
            m_pc = RESET_PC;
            m_ce = 1'b0;
            m_pend.delete();
        end else if (st[0]) begin
            if (be) begin
                m_pend.delete();
                m_pend.push_back(ba);
            end
        end else begin
            m_ce = 1'b1;
            if (be)                 m_pc = ba;
            else if (m_pend.size()) m_pc = m_pend[0];
            else                    m_pc = m_pc + 32'd4;
            m_pend.delete();
        end
        #1;
    endtask

    task automatic test_reset();
        step(1'b1, 6'h00, 1'b0, 32'h0);
        step(1'b1, 6'h00, 1'b1, 32'h1234_5678);
        vectors++;
        if (bus.if_to_id_bus !== {1'b0, RESET_PC} || bus.inst_sram_en !== 1'b0 ||
            bus.fetch_adel !== 1'b0 || bus.inst_sram_addr !== RESET_PC) begin
            miscompares++;
            $display("FAIL reset: bus=%h en=%b adel=%b addr=%h required bus=%h en=0 adel=0 addr=%h",
                     bus.if_to_id_bus, bus.inst_sram_en, bus.fetch_adel,
                     bus.inst_sram_addr, {1'b0, RESET_PC}, RESET_PC);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] want [3];
        want[0] = 32'hBFC0_0000;
        want[1] = 32'hBFC0_0004;
        want[2] = 32'hBFC0_0008;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 6'h00, 1'b0, 32'h0);
            vectors++;
            if (bus.if_to_id_bus !== {1'b1, want[i]} || bus.inst_sram_en !== 1'b1) begin
                miscompares++;
                $display("FAIL seq[%0d]: bus=%h en=%b required bus=%h en=1",
                         i, bus.if_to_id_bus, bus.inst_sram_en, {1'b1, want[i]});
            end
        end
    endtask

    task automatic test_branch();
        step(1'b0, 6'h00, 1'b1, 32'hBFC0_0100);
        vectors++;
        if (bus.if_to_id_bus !== {1'b1, 32'hBFC0_0100}) begin
            miscompares++;
            $display("FAIL branch_target: bus=%h required %h", bus.if_to_id_bus, {1'b1, 32'hBFC0_0100});
        end
        step(1'b0, 6'h00, 1'b0, 32'h0);
        step(1'b0, 6'h00, 1'b0, 32'h0);
        vectors++;
        if (bus.inst_sram_addr !== 32'hBFC0_0108) begin
            miscompares++;
            $display("FAIL branch_follow: addr=%h required %h", bus.inst_sram_addr, 32'hBFC0_0108);
        end
    endtask

    task automatic test_stall_redirect();
        step(1'b0, 6'h00, 1'b1, 32'hBFC0_0010);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 6'h01, (i == 1), 32'hBFC0_0200);
            vectors++;
            if (bus.if_to_id_bus !== {1'b1, 32'hBFC0_0010}) begin
                miscompares++;
                $display("FAIL stall_hold[%0d]: bus=%h required %h", i, bus.if_to_id_bus,
                         {1'b1, 32'hBFC0_0010});
            end
        end
        step(1'b0, 6'h00, 1'b0, 32'h0);
        vectors++;
        if (bus.inst_sram_addr !== 32'hBFC0_0200) begin
            miscompares++;
            $display("FAIL stall_pending: addr=%h required %h", bus.inst_sram_addr, 32'hBFC0_0200);
        end
        step(1'b0, 6'h00, 1'b0, 32'h0);
        vectors++;
        if (bus.inst_sram_addr !== 32'hBFC0_0204) begin
            miscompares++;
            $display("FAIL pending_cleared: addr=%h required %h", bus.inst_sram_addr, 32'hBFC0_0204);
        end
    endtask

    task automatic test_live_beats_pending();
        step(1'b0, 6'h01, 1'b1, 32'hBFC0_0200);
        step(1'b0, 6'h00, 1'b1, 32'hBFC0_0300);
        vectors++;
        if (bus.inst_sram_addr !== 32'hBFC0_0300) begin
            miscompares++;
            $display("FAIL live_over_pending: addr=%h required %h", bus.inst_sram_addr, 32'hBFC0_0300);
        end
        step(1'b0, 6'h00, 1'b0, 32'h0);
        vectors++;
        if (bus.inst_sram_addr !== 32'hBFC0_0304) begin
            miscompares++;
            $display("FAIL pending_discarded: addr=%h required %h", bus.inst_sram_addr, 32'hBFC0_0304);
        end
    endtask

    task automatic test_misaligned();
        step(1'b0, 6'h00, 1'b1, 32'hBFC0_0102);
        vectors++;
        if (bus.fetch_adel !== 1'b1 || bus.inst_sram_en !== 1'b0 ||
            bus.if_to_id_bus !== {1'b1, 32'hBFC0_0102}) begin
            miscompares++;
            $display("FAIL misaligned: adel=%b en=%b bus=%h required adel=1 en=0 bus=%h",
                     bus.fetch_adel, bus.inst_sram_en, bus.if_to_id_bus, {1'b1, 32'hBFC0_0102});
        end
        step(1'b0, 6'h00, 1'b0, 32'h0);
        vectors++;
        if (bus.fetch_adel !== 1'b1 || bus.inst_sram_en !== 1'b0 ||
            bus.inst_sram_addr !== 32'hBFC0_0106) begin
            miscompares++;
            $display("FAIL misaligned_next: adel=%b en=%b addr=%h required adel=1 en=0 addr=%h",
                     bus.fetch_adel, bus.inst_sram_en, bus.inst_sram_addr, 32'hBFC0_0106);
        end
        step(1'b0, 6'h00, 1'b1, 32'hBFC0_0400);
        vectors++;
        if (bus.fetch_adel !== 1'b0 || bus.inst_sram_en !== 1'b1) begin
            miscompares++;
            $display("FAIL realigned: adel=%b en=%b required adel=0 en=1",
                     bus.fetch_adel, bus.inst_sram_en);
        end
    endtask

    task automatic test_wrap();
        step(1'b0, 6'h00, 1'b1, 32'hFFFF_FFF8);
        step(1'b0, 6'h00, 1'b0, 32'h0);
        step(1'b0, 6'h00, 1'b0, 32'h0);
        vectors++;
        if (bus.if_to_id_bus !== {1'b1, 32'h0000_0000} || bus.inst_sram_en !== 1'b1) begin
            miscompares++;
            $display("FAIL wrap: bus=%h en=%b required bus=%h en=1",
                     bus.if_to_id_bus, bus.inst_sram_en, {1'b1, 32'h0});
        end
    endtask

    task automatic test_reset_mid_stall();
        step(1'b0, 6'h01, 1'b1, 32'hBFC0_0500);
        step(1'b1, 6'h01, 1'b1, 32'hBFC0_0600);
        vectors++;
        if (bus.if_to_id_bus !== {1'b0, RESET_PC} || bus.inst_sram_en !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_stall: bus=%h en=%b required bus=%h en=0",
                     bus.if_to_id_bus, bus.inst_sram_en, {1'b0, RESET_PC});
        end
        step(1'b0, 6'h00, 1'b0, 32'h0);
        vectors++;
        if (bus.if_to_id_bus !== {1'b1, 32'hBFC0_0000}) begin
            miscompares++;
            $display("FAIL reset_drops_pending: bus=%h required %h",
                     bus.if_to_id_bus, {1'b1, 32'hBFC0_0000});
        end
    endtask

    task automatic test_random();
        logic        r;
        logic [5:0]  st;
        logic        be;
        logic [31:0] ba;
        logic [102:0] obs;
        logic [102:0] exp_v;
        for (int i = 0; i < 600; i++) begin
            r  = ($urandom_range(0, 49) == 0);
            st = 6'($urandom);
            st[0] = ($urandom_range(0, 2) == 0);
            be = ($urandom_range(0, 3) == 0);
            ba = $urandom;
            if ($urandom_range(0, 7) != 0) ba[1:0] = 2'b00;
            step(r, st, be, ba);
            obs   = observe_vec();
            exp_v = expect_vec();
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL random[%0d]: got %h required %h", i, obs, exp_v);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        m_pc        = RESET_PC;
        m_ce        = 1'b0;
        rst         = 1'b1;
        bus.stall   = '0;
        bus.br_bus  = '0;
        test_reset();
        test_sequential();
        test_branch();
        test_stall_redirect();
        test_live_beats_pending();
        test_misaligned();
        test_wrap();
        test_reset_mid_stall();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
